// File: rtl/jt49_bus_master_if.sv
// Command stream, read return and PSG register bus for jt49_bus_master.
// slave: the bus master block (takes commands, drives the PSG).
// master: the host side (issues commands, models the PSG).
interface jt49_bus_master_if #(
    parameter int WAIT_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [3:0]        cmd_addr;
    logic [WAIT_W-1:0] cmd_data;
    logic              rd_valid;
    logic [7:0]        rd_data;
    logic              busy;
    logic [3:0]        psg_addr;
    logic              psg_cs_n;
    logic              psg_wr_n;
    logic [7:0]        psg_dout;
    logic [7:0]        psg_din;

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, psg_din,
        output cmd_ready, rd_valid, rd_data, busy,
               psg_addr, psg_cs_n, psg_wr_n, psg_dout
    );

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, psg_din,
        input  cmd_ready, rd_valid, rd_data, busy,
               psg_addr, psg_cs_n, psg_wr_n, psg_dout
    );
endinterface

// File: rtl/jt49_bus_master.sv
// jt49_bus_master: queues write/read/wait/nop commands in a FIFO and plays
// them onto the jt49 register port, holding each access until cen samples it.
// Optional feature macro: JT49_BUS_READ_EN enables the read op (bus read plus
// rd_data/rd_valid return). Without it a read is popped and dropped like a nop.
module jt49_bus_master #(
    parameter int FIFO_AW = 4,
    parameter int WAIT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cen,
    jt49_bus_master_if.slave   bus
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_COUNT = DEPTH[FIFO_AW:0];

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_READ  = 2'd1,
        OP_WAIT  = 2'd2,
        OP_NOP   = 2'd3
    } op_e;

    typedef struct packed {
        op_e               op;
        logic [3:0]        addr;
        logic [WAIT_W-1:0] data;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2
`ifdef JT49_BUS_READ_EN
        , S_CAPTURE = 2'd3
`endif
    } state_e;

    cmd_t                fifo_mem [DEPTH];
    cmd_t                wr_cmd;
    cmd_t                head;
    logic [FIFO_AW-1:0]  wr_ptr;
    logic [FIFO_AW-1:0]  rd_ptr;
    logic [FIFO_AW:0]    count;
    logic                full;
    logic                push;
    logic                pop;

    state_e              state;
    state_e              state_nx;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [WAIT_W-1:0]   wait_cnt_nx;
    logic                cs_n_q, cs_n_nx;
    logic                wr_n_q, wr_n_nx;
    logic [3:0]          addr_q, addr_nx;
    logic [7:0]          dout_q, dout_nx;

    // Ready comes from the registered count only, and is held low during reset.
    assign full           = (count == FULL_COUNT);
    assign bus.cmd_ready  = !rst && !full;
    assign push           = bus.cmd_valid && bus.cmd_ready;
    assign head           = fifo_mem[rd_ptr];
    assign bus.busy       = (count != '0) || (state != S_IDLE);

    // Pack the incoming command for storage.
    always_comb begin
        wr_cmd.op   = op_e'(bus.cmd_op);
        wr_cmd.addr = bus.cmd_addr;
        wr_cmd.data = bus.cmd_data;
    end

    // FIFO storage array.
    // NOTE: storage is deliberately not reset; count/pointers define validity,
    // and a resettable array would turn plain RAM into a wall of flops.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= wr_cmd;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at 2**FIFO_AW.
    // NOTE: non-blocking assignments in clocked blocks so every register samples
    // pre-edge values regardless of statement or process order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // FSM next-state decode.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    case (head.op)
                        OP_WRITE: state_nx = S_ACCESS;
`ifdef JT49_BUS_READ_EN
                        OP_READ:  state_nx = S_ACCESS;
`endif
                        OP_WAIT:  state_nx = S_WAIT;
                        default:  state_nx = S_IDLE;
                    endcase
                end
            end
            S_ACCESS: begin
`ifdef JT49_BUS_READ_EN
                // wr_n still high at the sampling edge marks a read in flight.
                if (cen) state_nx = wr_n_q ? S_CAPTURE : S_IDLE;
`else
                if (cen) state_nx = S_IDLE;
`endif
            end
`ifdef JT49_BUS_READ_EN
            S_CAPTURE: state_nx = S_IDLE;
`endif
            S_WAIT: begin
                if (cen && (wait_cnt == '0)) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

`ifdef JT49_BUS_READ_EN
    logic       rd_valid_q, rd_valid_nx;
    logic [7:0] rd_data_q, rd_data_nx;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
`else
    assign bus.rd_valid = 1'b0;
    assign bus.rd_data  = 8'h00;
`endif

    // FSM outputs: FIFO pop and next values of the registered bus signals.
    always_comb begin
        pop         = 1'b0;
        cs_n_nx     = cs_n_q;
        wr_n_nx     = wr_n_q;
        addr_nx     = addr_q;
        dout_nx     = dout_q;
        wait_cnt_nx = wait_cnt;
`ifdef JT49_BUS_READ_EN
        rd_valid_nx = 1'b0;
        rd_data_nx  = rd_data_q;
`endif
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    pop = 1'b1;
                    case (head.op)
                        OP_WRITE: begin
                            cs_n_nx = 1'b0;
                            wr_n_nx = 1'b0;
                            addr_nx = head.addr;
                            dout_nx = head.data[7:0];
                        end
`ifdef JT49_BUS_READ_EN
                        OP_READ: begin
                            cs_n_nx = 1'b0;
                            wr_n_nx = 1'b1;
                            addr_nx = head.addr;
                        end
`endif
                        OP_WAIT: wait_cnt_nx = head.data;
                        default: ;
                    endcase
                end
            end
            S_ACCESS: begin
                if (cen) begin
                    cs_n_nx = 1'b1;
                    wr_n_nx = 1'b1;
                end
            end
`ifdef JT49_BUS_READ_EN
            S_CAPTURE: begin
                rd_valid_nx = 1'b1;
                rd_data_nx  = bus.psg_din;
            end
`endif
            S_WAIT: begin
                if (cen && (wait_cnt != '0)) wait_cnt_nx = wait_cnt - 1'b1;
            end
            default: ;
        endcase
    end

    // Output and counter registers; reset releases the bus immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            addr_q     <= 4'h0;
            dout_q     <= 8'h00;
            wait_cnt   <= '0;
`ifdef JT49_BUS_READ_EN
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'h00;
`endif
        end else begin
            cs_n_q     <= cs_n_nx;
            wr_n_q     <= wr_n_nx;
            addr_q     <= addr_nx;
            dout_q     <= dout_nx;
            wait_cnt   <= wait_cnt_nx;
`ifdef JT49_BUS_READ_EN
            rd_valid_q <= rd_valid_nx;
            rd_data_q  <= rd_data_nx;
`endif
        end
    end

    assign bus.psg_cs_n = cs_n_q;
    assign bus.psg_wr_n = wr_n_q;
    assign bus.psg_addr = addr_q;
    assign bus.psg_dout = dout_q;

endmodule

// File: tb/tb_jt49_bus_master.sv
// Self-checking bench for jt49_bus_master with a small jt49 register model.
// Read expectations follow JT49_BUS_READ_EN when it is defined.
module tb_jt49_bus_master;
    localparam logic [1:0] OP_WR   = 2'd0;
    localparam logic [1:0] OP_RD   = 2'd1;
    localparam logic [1:0] OP_WAIT = 2'd2;
    localparam logic [1:0] OP_NOP  = 2'd3;
`ifdef JT49_BUS_READ_EN
    localparam bit RD_EN = 1'b1;
`else
    localparam bit RD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cen = 1'b0;
    logic cen_en = 1'b0;
    logic [3:0] div = 4'd0;
    logic model_clr = 1'b1;

    int n_vec  = 0;
    int n_miss = 0;

    jt49_bus_master_if #(.WAIT_W(16)) bus ();

    jt49_bus_master #(.FIFO_AW(4), .WAIT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .cen (cen),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // cen: one pulse every 16 clocks when enabled, changed on the falling edge
    always @(negedge clk) begin
        div <= div + 4'd1;
        cen <= cen_en && (div == 4'd15);
    end

    // jt49 register model plus bus/read monitors
    logic [7:0]  psg_reg [16];
    logic [11:0] wr_log [$];
    int          strobes = 0;
    int          rd_pulses = 0;
    logic        rd_prev = 1'b0;
    logic        long_pulse = 1'b0;

    assign bus.psg_din = psg_reg[bus.psg_addr];

    always @(posedge clk) begin
        if (model_clr) begin
            for (int i = 0; i < 16; i++) psg_reg[i] <= 8'h00;
        end else if (cen && !bus.psg_cs_n && !bus.psg_wr_n) begin
            psg_reg[bus.psg_addr] <= bus.psg_dout;
            wr_log.push_back({bus.psg_addr, bus.psg_dout});
        end
        if (cen && !bus.psg_cs_n) strobes <= strobes + 1;
        if (bus.rd_valid) rd_pulses <= rd_pulses + 1;
        if (bus.rd_valid && rd_prev) long_pulse <= 1'b1;
        rd_prev <= bus.rd_valid;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [1:0] op, input logic [3:0] addr,
                            input logic [15:0] data, output bit accepted);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = addr;
        bus.cmd_data  = data;
        accepted      = bus.cmd_ready;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles, input string name);
        for (int i = 0; i < max_cycles && bus.busy; i++) tick();
        check(name, bus.busy, 0);
    endtask

    task automatic wait_cs_low(input int max_cycles, input string name);
        for (int i = 0; i < max_cycles && bus.psg_cs_n; i++) tick();
        check(name, bus.psg_cs_n, 0);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  addr;
        logic [15:0] data;
        logic [3:0]  chk_addr;
        logic [7:0]  exp_reg;
        int          exp_strobes;
        int          exp_rd_pulses;
        logic [7:0]  exp_rd_data;
    } vec_t;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [10];
        bit          acc;
        int          s0, p0, cnt;
        logic [7:0]  rv0, rv1;

        rv0 = RD_EN ? 8'h5A : 8'h00;
        rv1 = RD_EN ? 8'h81 : 8'h00;
        vecs[0] = '{OP_WR,   4'd0,  16'h005A, 4'd0,  8'h5A, 1,         0,         8'h00};
        vecs[1] = '{OP_RD,   4'd0,  16'h0000, 4'd0,  8'h5A, int'(RD_EN), int'(RD_EN), rv0};
        vecs[2] = '{OP_WR,   4'd1,  16'h00FF, 4'd1,  8'hFF, 1,         0,         rv0};
        vecs[3] = '{OP_WAIT, 4'd0,  16'h0002, 4'd1,  8'hFF, 0,         0,         rv0};
        vecs[4] = '{OP_NOP,  4'd5,  16'h0055, 4'd5,  8'h00, 0,         0,         rv0};
        vecs[5] = '{OP_WR,   4'd15, 16'h0081, 4'd15, 8'h81, 1,         0,         rv0};
        vecs[6] = '{OP_RD,   4'd15, 16'h0000, 4'd15, 8'h81, int'(RD_EN), int'(RD_EN), rv1};
        vecs[7] = '{OP_WR,   4'd8,  16'hAB45, 4'd8,  8'h45, 1,         0,         rv1};
        vecs[8] = '{OP_WAIT, 4'd0,  16'h0000, 4'd8,  8'h45, 0,         0,         rv1};
        vecs[9] = '{OP_RD,   4'd13, 16'h0000, 4'd13, 8'h00, int'(RD_EN), int'(RD_EN), 8'h00};

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_addr  = 4'd0;
        bus.cmd_data  = 16'd0;

        // Reset state
        repeat (3) tick();
        check("rst_cs_n",      bus.psg_cs_n,  1);
        check("rst_wr_n",      bus.psg_wr_n,  1);
        check("rst_addr",      bus.psg_addr,  0);
        check("rst_dout",      bus.psg_dout,  0);
        check("rst_rd_valid",  bus.rd_valid,  0);
        check("rst_rd_data",   bus.rd_data,   0);
        check("rst_busy",      bus.busy,      0);
        check("rst_cmd_ready", bus.cmd_ready, 0);
        model_clr = 1'b0;
        rst = 1'b0;
        cen_en = 1'b1;
        tick();
        check("post_rst_cmd_ready", bus.cmd_ready, 1);

        // Table: one command at a time, cen every 16 clocks
        for (int v = 0; v < 10; v++) begin
            s0 = strobes;
            p0 = rd_pulses;
            push_cmd(vecs[v].op, vecs[v].addr, vecs[v].data, acc);
            check($sformatf("v%0d_accept", v), acc, 1);
            wait_idle(300, $sformatf("v%0d_idle", v));
            repeat (2) tick();
            check($sformatf("v%0d_reg", v),       psg_reg[vecs[v].chk_addr], vecs[v].exp_reg);
            check($sformatf("v%0d_strobes", v),   strobes - s0,   vecs[v].exp_strobes);
            check($sformatf("v%0d_rd_pulses", v), rd_pulses - p0, vecs[v].exp_rd_pulses);
            check($sformatf("v%0d_rd_data", v),   bus.rd_data,    vecs[v].exp_rd_data);
        end

        // Write addr 7 = 0x38: bus held until the cen edge, released right after
        push_cmd(OP_WR, 4'd7, 16'h0038, acc);
        wait_cs_low(10, "t1_cs_low");
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (cen) begin
                cnt = 1;
                break;
            end
            check("t1_hold", {bus.psg_cs_n, bus.psg_wr_n, bus.psg_addr, bus.psg_dout},
                  {1'b0, 1'b0, 4'd7, 8'h38});
        end
        check("t1_cen_seen", cnt, 1);
        check("t1_released", {bus.psg_cs_n, bus.psg_wr_n}, 2'b11);
        tick();
        check("t1_idle_gap", bus.psg_cs_n, 1);
        check("t1_reg7", psg_reg[7], 8'h38);

        // Fill: w0 stalls in ACCESS (cen off), w1..w16 fill 16 entries, w17 refused
        cen_en = 1'b0;
        repeat (3) tick();
        s0 = wr_log.size();
        cnt = 0;
        for (int i = 0; i < 17; i++) begin
            push_cmd(OP_WR, 4'(i), 16'(8'h20 + i), acc);
            if (acc) cnt++;
        end
        check("t3_accepted", cnt, 17);
        check("t3_ready_full", bus.cmd_ready, 0);
        push_cmd(OP_WR, 4'd1, 16'h00EE, acc);
        check("t3_refused", acc, 0);
        check("t3_busy", bus.busy, 1);
        cen_en = 1'b1;
        wait_idle(2000, "t3_drain");
        check("t3_log_size", wr_log.size() - s0, 17);
        for (int i = 0; i < 17; i++) begin
            if (s0 + i < wr_log.size())
                check($sformatf("t3_order%0d", i), wr_log[s0 + i], {4'(i), 8'(8'h20 + i)});
        end

        // Wait n then write: write starts after n+1 cen edges in WAIT
        for (int n = 0; n <= 3; n += 3) begin
            push_cmd(OP_WAIT, 4'd0, 16'(n), acc);
            push_cmd(OP_WR, 4'd8, 16'(8'h0C + n), acc);
            cnt = 0;
            for (int i = 0; i < 200 && bus.psg_cs_n; i++) begin
                tick();
                if (bus.psg_cs_n && cen) cnt++;
            end
            check($sformatf("t4_wait%0d_cs", n), bus.psg_cs_n, 0);
            check($sformatf("t4_wait%0d_cens", n), cnt, n + 1);
            wait_idle(200, "t4_idle");
            tick();
            check($sformatf("t4_wait%0d_reg8", n), psg_reg[8], 8'(8'h0C + n));
        end

        // Reset in the middle of a write access
        cen_en = 1'b0;
        repeat (3) tick();
        s0 = strobes;
        push_cmd(OP_WR, 4'd2, 16'h0077, acc);
        push_cmd(OP_WR, 4'd3, 16'h0066, acc);
        wait_cs_low(10, "t5_cs_low");
        rst = 1'b1;
        tick();
        check("t5_cs_n",  bus.psg_cs_n, 1);
        check("t5_wr_n",  bus.psg_wr_n, 1);
        check("t5_busy",  bus.busy, 0);
        check("t5_ready", bus.cmd_ready, 0);
        rst = 1'b0;
        cen_en = 1'b1;
        repeat (100) tick();
        check("t5_busy_after", bus.busy, 0);
        check("t5_strobes", strobes - s0, 0);
        check("t5_reg2", psg_reg[2], 8'h22);
        check("t5_reg3", psg_reg[3], 8'h23);
        check("t5_ready_after", bus.cmd_ready, 1);

        check("rd_pulse_width", long_pulse, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
